// File: rtl/derm_bit_packer.sv
// derm_bit_packer: packs variable-length LSB-first segments into dense
// DATA_WIDTH-bit words, flushing a final partial word on last.
module derm_bit_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]  in_len,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic                  out_last
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = LEN_WIDTH + 1;
  localparam logic [CW-1:0]        C_W = CW'(W);
  localparam logic [LEN_WIDTH-1:0] L_W = LEN_WIDTH'(W);

  logic [2*W-1:0]       r_buf;
  logic [CW-1:0]        r_cnt;
  logic                 r_last_pend;

  logic [LEN_WIDTH-1:0] w_len;
  logic [W-1:0]         w_mask;
  logic [W-1:0]         w_seg;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_acc;
  logic [2*W-1:0]       w_buf_p;
  logic [2*W-1:0]       w_buf_n;
  logic [CW-1:0]        w_cnt_p;
  logic [CW-1:0]        w_cnt_n;
  logic                 w_lp_p;
  logic                 w_lp_n;

  assign w_len = (in_len > L_W) ? L_W : in_len;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < W; i++)
      w_mask[i] = (w_len > LEN_WIDTH'(i));
  end

  assign w_seg     = in_data & w_mask;
  assign w_full    = (r_cnt >= C_W);
  assign out_valid = w_full || r_last_pend;
  assign out_len   = w_full ? L_W : r_cnt[LEN_WIDTH-1:0];
  assign out_data  = r_buf[W-1:0];
  assign out_last  = r_last_pend && (r_cnt <= C_W);
  assign w_pop     = out_valid && out_ready;

  // out_ready feeds in_ready directly so a full word can drain
  // in the same cycle a new segment lands
  assign in_ready = rst_n && !r_last_pend
                 && (!w_full || out_ready);
  assign w_acc    = in_valid && in_ready;

  always_comb begin
    w_buf_p = r_buf;
    w_cnt_p = r_cnt;
    w_lp_p  = r_last_pend;
    if (w_pop && out_last) begin
      w_buf_p = '0;
      w_cnt_p = '0;
      w_lp_p  = 1'b0;
    end else if (w_pop) begin
      w_buf_p = r_buf >> W;
      w_cnt_p = r_cnt - C_W;
    end
    w_buf_n = w_buf_p;
    w_cnt_n = w_cnt_p;
    w_lp_n  = w_lp_p;
    if (w_acc) begin
      w_buf_n = w_buf_p
              | ({{W{1'b0}}, w_seg} << w_cnt_p);
      w_cnt_n = w_cnt_p + CW'(w_len);
      w_lp_n  = w_lp_p | in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_last_pend <= 1'b0;
    end else begin
      r_buf       <= w_buf_n;
      r_cnt       <= w_cnt_n;
      r_last_pend <= w_lp_n;
    end
  end

endmodule

// File: tb/tb_derm_bit_packer.sv
// tb_derm_bit_packer: directed table plus randomized stimulus checked
// against a bit-queue reference model.
module tb_derm_bit_packer;

  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [LW-1:0] in_len;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [LW-1:0] out_len;
  logic          out_last;

  derm_bit_packer #(
    .DATA_WIDTH(W),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_len  (out_len),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] l;
    logic       lst;
  } word_t;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [3:0] l;
    logic       lst;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic [3:0] ol;
    logic       olast;
    logic       ir;
  } tv_t;

  tv_t   tvq[$];
  word_t exp_q[$];
  logic  mq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  logic       s_ov, s_olast, s_ir, s_acc;
  logic [7:0] s_od;
  logic [3:0] s_ol;
  logic       p_stall;
  logic [7:0] p_d;
  logic [3:0] p_l;
  logic       p_last;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic emit(input int k, input logic lst);
    word_t w;
    w.d = '0;
    for (int i = 0; i < k; i++) w.d[i] = mq.pop_front();
    w.l   = 4'(k);
    w.lst = lst;
    exp_q.push_back(w);
  endtask

  // Reference: a block is one bit stream cut into 8-bit words; the final
  // word carries last, and a last landing on an empty residue is an
  // empty word.
  task automatic model_accept(input logic [7:0] d,
                              input logic [3:0] l,
                              input logic lst);
    int n;
    int k;
    n = (l > 4'd8) ? 8 : int'(l);
    for (int i = 0; i < n; i++) mq.push_back(d[i]);
    if (!lst) begin
      while (mq.size() >= 8) emit(8, 1'b0);
    end else if (mq.size() == 0) begin
      exp_q.push_back('{8'h00, 4'd0, 1'b1});
    end else begin
      while (mq.size() > 0) begin
        k = (mq.size() > 8) ? 8 : mq.size();
        emit(k, mq.size() == k);
      end
    end
  endtask

  task automatic cyc();
    word_t e;
    @(negedge clk);
    s_ov    = out_valid;
    s_od    = out_data;
    s_ol    = out_len;
    s_olast = out_last;
    s_ir    = in_ready;
    s_acc   = rst_n && in_valid && in_ready;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      p_stall = 1'b0;
    end else begin
      if (p_stall)
        chk("stall_hold", 32'({s_ov, s_od, s_ol, s_olast}),
            32'({1'b1, p_d, p_l, p_last}));
      if (s_ov && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h len %0d last %b, expected none",
                   s_od, s_ol, s_olast);
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'({s_od, s_ol, s_olast}),
              32'({e.d, e.l, e.lst}));
        end
      end
      if (s_acc) model_accept(in_data, in_len, in_last);
      p_stall = s_ov && !out_ready;
      p_d     = s_od;
      p_l     = s_ol;
      p_last  = s_olast;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic [3:0] l,
                      input logic lst);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    in_last  = lst;
    do begin
      out_ready = 1'($urandom % 2);
      cyc();
      t++;
    end while (!s_acc && t < 50);
    if (!s_acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept, expected accept in 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && t < 100) begin
      cyc();
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic add(input logic iv, input logic [7:0] d,
                     input logic [3:0] l, input logic lst,
                     input logic ordy, input logic ov,
                     input logic [7:0] od, input logic [3:0] ol,
                     input logic olast, input logic ir);
    tvq.push_back('{iv, d, l, lst, ordy, ov, od, ol, olast, ir});
  endtask

  initial begin
    int base;
    tv_t v;
    //  iv d      l     lst ordy | ov od     ol    olast ir
    add(1, 8'hFF, 4'd3, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'hFF, 4'd3, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h00, 4'd2, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'hAB, 4'd8, 1, 1,   1, 8'h3F, 4'd8, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'hAB, 4'd8, 1, 0);
    add(0, 8'h00, 4'd0, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h05, 4'd3, 1, 1,   0, 8'h00, 4'd0, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'h05, 4'd3, 1, 0);
    add(1, 8'hFD, 4'd3, 1, 1,   0, 8'h00, 4'd0, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'h05, 4'd3, 1, 0);
    add(1, 8'hFF, 4'd0, 1, 1,   0, 8'h00, 4'd0, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'h00, 4'd0, 1, 0);
    add(0, 8'h00, 4'd0, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h5A, 4'd12, 1, 1,  0, 8'h00, 4'd0, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'h5A, 4'd8, 1, 0);
    add(0, 8'h00, 4'd0, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h11, 4'd8, 0, 0,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h22, 4'd8, 0, 0,   1, 8'h11, 4'd8, 0, 0);
    add(1, 8'h22, 4'd8, 0, 1,   1, 8'h11, 4'd8, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'h22, 4'd8, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h33, 4'd8, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h0C, 4'd4, 1, 1,   1, 8'h33, 4'd8, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'h0C, 4'd4, 1, 0);
    add(0, 8'h00, 4'd0, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'h44, 4'd8, 0, 1,   0, 8'h00, 4'd0, 0, 1);
    add(1, 8'hFF, 4'd0, 1, 1,   1, 8'h44, 4'd8, 0, 1);
    add(0, 8'h00, 4'd0, 0, 1,   1, 8'h00, 4'd0, 1, 0);
    add(0, 8'h00, 4'd0, 0, 1,   0, 8'h00, 4'd0, 0, 1);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    p_stall   = 1'b0;
    @(posedge clk);
    #1;
    cyc();

    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_len    = 4'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      cyc();
      chk("reset_out",
          32'({s_ov, s_od, s_ol, s_olast, s_ir}), 32'd0);
    end

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    chk("post_reset", 32'({s_ir, s_ov}), 32'b10);

    foreach (tvq[i]) begin
      v = tvq[i];
      in_valid  = v.iv;
      in_data   = v.d;
      in_len    = v.l;
      in_last   = v.lst;
      out_ready = v.ordy;
      cyc();
      if (v.ov)
        chk($sformatf("tv%0d", i),
            32'({s_ov, s_od, s_ol, s_olast, s_ir}),
            32'({v.ov, v.od, v.ol, v.olast, v.ir}));
      else
        chk($sformatf("tv%0d", i),
            32'({s_ov, s_ir}), 32'({1'b0, v.ir}));
    end

    base = n_pops;
    for (int i = 0; i < 20; i++)
      send(8'($urandom), (i == 5) ? 4'd12 : 4'd8, i == 19);
    drain();
    chk("bp_count", 32'(n_pops - base), 32'd20);

    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      in_len    = 4'($urandom_range(0, 12));
      in_last   = ($urandom % 8) == 0;
      out_ready = 1'($urandom % 2);
      cyc();
    end
    send(8'($urandom), 4'($urandom_range(0, 12)), 1'b1);
    drain();

    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_len   = 4'd8;
      in_last  = 1'b0;
      cyc();
      chk("tput_ready", 32'(s_ir), 32'd1);
      if (k > 0) chk("tput_valid", 32'(s_ov), 32'd1);
    end
    in_data = 8'h07;
    in_len  = 4'd5;
    cyc();
    chk("tput_acc5", 32'(s_acc), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_reset_idle", 32'({s_ov, s_ir}), 32'b01);
    cyc();
    chk("mid_reset_idle2", 32'({s_ov, s_ir}), 32'b01);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_len   = 4'd2;
    in_last  = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("mid_reset_word",
        32'({s_ov, s_od, s_ol, s_olast}),
        32'({1'b1, 8'h03, 4'd2, 1'b1}));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
